// File: rtl/ins_cache_loader.sv
// ins_cache_loader
//
// Instruction cache sequencer. Loads fixed windows of ISA_DEPTH instructions
// from DDR into a local buffer in bursts of BURST_LEN words. Serves
// instructions to AP_ctrl at the PC address. Publishes the residency handshake
// (ins_cache_rdy, st_cur_ins_cache, load_times) that program_counter uses to
// decide when it may advance.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   addr_ins          current PC from program_counter
//   ins_req           AP_ctrl request for the instruction at addr_ins
//   ins_out           instruction data (held between strobes)
//   ins_out_valid     one-cycle strobe, ins_out valid
//   ins_cache_rdy     window holding addr_ins is resident
//   st_cur_ins_cache  FSM state code (IDLE=0, LOAD_REQ=1, LOAD_DATA=2,
//                     SENT_INS=3, CHECK=4)
//   load_times        resident window index + 1 (0 = nothing loaded)
//   ddr_rd_req        burst read request, held until ddr_rd_gnt
//   ddr_rd_addr       burst start byte address (0 when not requesting)
//   ddr_rd_gnt        arbiter accepts the request
//   ddr_rd_data       read data
//   ddr_rd_data_vld   read data beat valid
//
// Optional build macro INS_LOAD_STATS_EN:
//   adds output refill_cnt[15:0]. It counts completed window loads and
//   saturates at 0xFFFF.

module ins_cache_loader #(
  parameter int ADDR_WIDTH_MEM  = 16,
  parameter int ISA_DEPTH       = 64,
  parameter int TOTAL_ISA_DEPTH = 128,
  parameter int DDR_ADDR_WIDTH  = 28,
  parameter int INS_WIDTH       = 64,
  parameter int BURST_LEN       = 8,
  parameter logic [DDR_ADDR_WIDTH-1:0] INS_BASE_ADDR = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
  input  logic                      ins_req,
  output logic [INS_WIDTH-1:0]      ins_out,
  output logic                      ins_out_valid,
  output logic                      ins_cache_rdy,
  output logic [3:0]                st_cur_ins_cache,
  output logic [9:0]                load_times,
  output logic                      ddr_rd_req,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
  input  logic                      ddr_rd_gnt,
  input  logic [INS_WIDTH-1:0]      ddr_rd_data,
  input  logic                      ddr_rd_data_vld
`ifdef INS_LOAD_STATS_EN
  ,
  output logic [15:0]               refill_cnt
`endif
);

  localparam int IDX_W = $clog2(ISA_DEPTH);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  // Wide enough for window bounds of any 10-bit window index.
  localparam int WW    = ADDR_WIDTH_MEM + 12;
  localparam logic [IDX_W-1:0] LAST_BEAT_BASE = IDX_W'(ISA_DEPTH - BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT      = CNT_W'(BURST_LEN - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LOAD_REQ  = 4'd1,
    LOAD_DATA = 4'd2,
    SENT_INS  = 4'd3,
    CHECK     = 4'd4
  } state_t;

  state_t state, next_state;

  logic [9:0]           target;
  logic [IDX_W-1:0]     beat_base;
  logic [CNT_W-1:0]     beat_cnt;
  logic [INS_WIDTH-1:0] ins_buf [ISA_DEPTH];

  logic [WW-1:0] addr_ext, win_lo, win_hi, tgt_lo, tgt_hi;
  logic          in_prog, resident, tgt_hit, burst_end, load_done, rdy_next;

  assign addr_ext  = WW'(addr_ins);
  assign win_hi    = WW'(load_times) << IDX_W;
  assign win_lo    = win_hi - WW'(ISA_DEPTH);
  assign tgt_lo    = WW'(target) << IDX_W;
  assign tgt_hi    = tgt_lo + WW'(ISA_DEPTH);
  assign in_prog   = addr_ext < WW'(TOTAL_ISA_DEPTH);
  assign resident  = (load_times != '0) && (addr_ext >= win_lo) &&
                     (addr_ext < win_hi) && in_prog;
  // Residency against the window that is currently being loaded. It is used
  // to set ins_cache_rdy on the cycle the load completes.
  assign tgt_hit   = (addr_ext >= tgt_lo) && (addr_ext < tgt_hi) && in_prog;
  assign burst_end = (state == LOAD_DATA) && ddr_rd_data_vld && (beat_cnt == LAST_BEAT);
  assign load_done = burst_end && (beat_base == LAST_BEAT_BASE);

  assign st_cur_ins_cache = state;
  assign ddr_rd_req       = (state == LOAD_REQ);
  assign ddr_rd_addr      = ddr_rd_req ?
      INS_BASE_ADDR + (((DDR_ADDR_WIDTH'(target) << IDX_W) | DDR_ADDR_WIDTH'(beat_base)) << 3)
      : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    rdy_next   = 1'b0;
    case (state)
      IDLE:      next_state = LOAD_REQ;
      LOAD_REQ:  if (ddr_rd_gnt) next_state = LOAD_DATA;
      LOAD_DATA: begin
        if (burst_end) next_state = load_done ? SENT_INS : LOAD_REQ;
        rdy_next = load_done && tgt_hit;
      end
      SENT_INS: begin
        // Addresses past the program (including the 0x8000 pending-jump
        // address) park here without refilling. A PC one past the window is a
        // sequential refill. Anything else in the program is a jump.
        if (in_prog && !resident)
          next_state = (addr_ext == win_hi) ? LOAD_REQ : CHECK;
        rdy_next = resident;
      end
      CHECK:     next_state = LOAD_REQ;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target        <= '0;
      beat_base     <= '0;
      beat_cnt      <= '0;
      load_times    <= '0;
      ins_out       <= '0;
      ins_out_valid <= 1'b0;
      ins_cache_rdy <= 1'b0;
    end else begin
      ins_out_valid <= 1'b0;
      ins_cache_rdy <= rdy_next;
      case (state)
        IDLE: target <= '0;
        LOAD_DATA: begin
          if (ddr_rd_data_vld) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt  <= '0;
              // Wraps to zero after the final burst of the window.
              beat_base <= beat_base + IDX_W'(BURST_LEN);
              if (load_done)
                load_times <= (target == 10'h3FF) ? 10'h3FF : target + 10'd1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        SENT_INS: begin
          // Windows are aligned to ISA_DEPTH, so the low address bits are the
          // buffer offset.
          if (ins_req && resident) begin
            ins_out       <= ins_buf[addr_ins[IDX_W-1:0]];
            ins_out_valid <= 1'b1;
          end
          if (next_state == LOAD_REQ) target <= load_times;
        end
        CHECK: target <= 10'(addr_ins >> IDX_W);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD_DATA && ddr_rd_data_vld)
      ins_buf[beat_base + IDX_W'(beat_cnt)] <= ddr_rd_data;
  end

`ifdef INS_LOAD_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      refill_cnt <= '0;
    else if (load_done && refill_cnt != 16'hFFFF)
      refill_cnt <= refill_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ins_cache_loader.sv
// tb_ins_cache_loader
//
// Self-checking bench for ins_cache_loader. A DDR responder grants requests
// with random delays and returns bursts with random gaps from a random
// memory image. A window-level model predicts the following:
//   - which window must be resident
//   - the burst addresses a reload must issue
//   - whether a jump passes through CHECK
//   - the instruction word returned
// Build macro INS_LOAD_STATS_EN is mirrored here to connect refill_cnt.

module tb_ins_cache_loader;

  localparam int ISA_DEPTH = 64;
  localparam int TOTAL     = 128;
  localparam int BURST_LEN = 8;
  localparam int MAX_WAIT  = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr_ins;
  logic        ins_req;
  logic [63:0] ins_out;
  logic        ins_out_valid;
  logic        ins_cache_rdy;
  logic [3:0]  st_cur_ins_cache;
  logic [9:0]  load_times;
  logic        ddr_rd_req;
  logic [27:0] ddr_rd_addr;
  logic        ddr_rd_gnt;
  logic [63:0] ddr_rd_data;
  logic        ddr_rd_data_vld;
`ifdef INS_LOAD_STATS_EN
  logic [15:0] refill_cnt;
`endif

  always #5 clk = ~clk;

  ins_cache_loader dut (
    .clk              (clk),
    .rst              (rst),
    .addr_ins         (addr_ins),
    .ins_req          (ins_req),
    .ins_out          (ins_out),
    .ins_out_valid    (ins_out_valid),
    .ins_cache_rdy    (ins_cache_rdy),
    .st_cur_ins_cache (st_cur_ins_cache),
    .load_times       (load_times),
    .ddr_rd_req       (ddr_rd_req),
    .ddr_rd_addr      (ddr_rd_addr),
    .ddr_rd_gnt       (ddr_rd_gnt),
    .ddr_rd_data      (ddr_rd_data),
    .ddr_rd_data_vld  (ddr_rd_data_vld)
`ifdef INS_LOAD_STATS_EN
    ,
    .refill_cnt       (refill_cnt)
`endif
  );

  logic [63:0] ddr_mem [TOTAL];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          model_win   = -1;
  int          model_loads = 0;
  logic [27:0] req_log [$];
  bit          fast_gnt   = 1'b1;
  int          beat_total = 0;

  int          rsp_mode;
  int          rsp_wait;
  int          rsp_beats;
  logic [27:0] rsp_addr;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // DDR read responder.
  // Mode 0: idle. Mode 1: waiting to grant. Mode 2: streaming the burst.
  // It keeps streaming through a DUT reset so that stale beats reach the DUT.
  initial begin : ddr_model
    rsp_mode = 0;
    rsp_wait = 0;
    rsp_beats = 0;
    rsp_addr = '0;
    ddr_rd_gnt = 1'b0;
    ddr_rd_data_vld = 1'b0;
    ddr_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      ddr_rd_gnt = 1'b0;
      ddr_rd_data_vld = 1'b0;
      if (rsp_mode == 2) begin
        if ($urandom_range(0, 3) != 0) begin
          ddr_rd_data_vld = 1'b1;
          ddr_rd_data = ddr_mem[(int'(rsp_addr >> 3) + rsp_beats) % TOTAL];
          rsp_beats++;
          beat_total++;
          if (rsp_beats == BURST_LEN) rsp_mode = 0;
        end else begin
          ddr_rd_data = {$urandom, $urandom};
        end
      end else if (rsp_mode == 1) begin
        checkOutput("req_hold", {35'd0, ddr_rd_req, ddr_rd_addr}, {35'd0, 1'b1, rsp_addr});
        if (rsp_wait == 0) begin
          ddr_rd_gnt = 1'b1;
          rsp_mode = 2;
          rsp_beats = 0;
        end else begin
          rsp_wait--;
        end
      end else if (rst && ddr_rd_req) begin
        rsp_addr = ddr_rd_addr;
        req_log.push_back(ddr_rd_addr);
        rsp_wait = fast_gnt ? 0 : int'($urandom_range(0, 2));
        if (rsp_wait == 0) begin
          ddr_rd_gnt = 1'b1;
          rsp_mode = 2;
          rsp_beats = 0;
        end else begin
          rsp_wait--;
          rsp_mode = 1;
        end
      end
    end
  end

  // Move the PC to address a and let the cache settle. Then check residency,
  // the refill traffic and one instruction fetch against the window model.
  // When poke is set, an ins_req is issued mid-refill and must be dropped.
  task automatic applyStimulus(input int a, input bit poke);
    bit reload, exp_check, saw_check, done, do_poke;
    int exp_win, strobes, rdy_hi, reqs_seen;
    reload    = (a < TOTAL) && ((a / ISA_DEPTH) != model_win);
    exp_win   = reload ? a / ISA_DEPTH : model_win;
    exp_check = reload && (model_win >= 0) && (a != (model_win + 1) * ISA_DEPTH);
    do_poke   = poke && (reload || a >= TOTAL);
    req_log.delete();
    addr_ins  = 16'(a);
    ins_req   = 1'b0;
    saw_check = 1'b0;
    done      = 1'b0;
    strobes   = 0;
    rdy_hi    = 0;
    reqs_seen = 0;
    for (int i = 0; i < MAX_WAIT && !done; i++) begin
      @(posedge clk);
      #1;
      ins_req = do_poke && (i == 4);
      if (st_cur_ins_cache == 4'd4) saw_check = 1'b1;
      if (ins_out_valid) strobes++;
      if (ddr_rd_req) reqs_seen++;
      if (ins_cache_rdy && i >= 1) rdy_hi++;
      if (a < TOTAL) done = (i >= 6) && ins_cache_rdy;
      else           done = (i >= 20);
    end
    ins_req = 1'b0;
    if (!done) checkOutput("settle_timeout", 64'd0, 64'd1);
    if (a < TOTAL) begin
      checkOutput("load_times", 64'(load_times), 64'(exp_win + 1));
      checkOutput("state_sent", 64'(st_cur_ins_cache), 64'd3);
      checkOutput("saw_check", 64'(saw_check), 64'(exp_check));
      checkOutput("req_count", 64'(req_log.size()), reload ? 64'(ISA_DEPTH / BURST_LEN) : 64'd0);
      for (int k = 0; k < req_log.size() && k < ISA_DEPTH / BURST_LEN; k++)
        checkOutput("req_addr", 64'(req_log[k]),
                    64'((exp_win * ISA_DEPTH + k * BURST_LEN) * 8));
      if (reload) model_loads++;
    end else begin
      checkOutput("oob_no_req", 64'(reqs_seen), 64'd0);
      checkOutput("oob_rdy", 64'(rdy_hi), 64'd0);
      checkOutput("oob_state", 64'(st_cur_ins_cache), 64'd3);
      checkOutput("oob_load_times", 64'(load_times), 64'(model_win + 1));
    end
    if (do_poke) checkOutput("dropped_req", 64'(strobes), 64'd0);
    ins_req = 1'b1;
    @(posedge clk);
    #1;
    ins_req = 1'b0;
    checkOutput("valid", 64'(ins_out_valid), 64'(a < TOTAL));
    if (a < TOTAL) checkOutput("ins_out", ins_out, ddr_mem[a]);
    @(posedge clk);
    #1;
    checkOutput("valid_pulse", 64'(ins_out_valid), 64'd0);
`ifdef INS_LOAD_STATS_EN
    checkOutput("refill_cnt", 64'(refill_cnt), 64'(model_loads));
`endif
    model_win = exp_win;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_ins_out", ins_out, 64'd0);
    checkOutput("rst_valid", 64'(ins_out_valid), 64'd0);
    checkOutput("rst_rdy", 64'(ins_cache_rdy), 64'd0);
    checkOutput("rst_load_times", 64'(load_times), 64'd0);
    checkOutput("rst_ddr_req", 64'(ddr_rd_req), 64'd0);
    checkOutput("rst_ddr_addr", 64'(ddr_rd_addr), 64'd0);
    checkOutput("rst_state", 64'(st_cur_ins_cache), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int tgt, start, a;
    for (int i = 0; i < TOTAL; i++) ddr_mem[i] = {$urandom, $urandom};
    rst = 1'b0;
    addr_ins = '0;
    ins_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs();

    // Bring-up: immediate grants, window 0.
    rst = 1'b1;
    applyStimulus(0, 1'b0);
    fast_gnt = 1'b0;
    applyStimulus(5, 1'b0);

    // Sequential walk across the window boundary.
    for (int s = 60; s <= 66; s++) applyStimulus(s, s == 64);

    // Jump back, out-of-program park, then a jump into window 1.
    applyStimulus(10, 1'b1);
    applyStimulus(16'h8000, 1'b1);
    applyStimulus(70, 1'b1);
    applyStimulus(127, 1'b0);

    // Random PC moves.
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 4) == 0)
        a = ($urandom_range(0, 1) == 0) ? 16'h8000 : int'($urandom_range(TOTAL, 16'hFFFF));
      else
        a = int'($urandom_range(0, TOTAL - 1));
      applyStimulus(a, $urandom_range(0, 1) == 1);
    end

    // Reset a few beats into a refill burst.
    tgt = (model_win == 0) ? 100 : 20;
    req_log.delete();
    addr_ins = 16'(tgt);
    start = beat_total;
    for (int i = 0; i < MAX_WAIT && beat_total < start + 3; i++) begin
      @(posedge clk);
      #1;
    end
    if (beat_total < start + 3) checkOutput("beat_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    addr_ins = 16'd3;
    #1;
    checkResetOutputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_win = -1;
    model_loads = 0;
    applyStimulus(3, 1'b0);
    applyStimulus(64, 1'b1);
    applyStimulus(33, 1'b1);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
